// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write-port arbiter: pipeline writeback vs 2-deep multi-cycle result FIFO
// Optional starvation guard enabled by defining RF_ARB_FAIRNESS_EN.
module regfile_wr_arbiter #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_addr_i,
    input  logic [31:0] pipe_rd_data_i,
    input  logic        mc_valid_i,
    input  logic [4:0]  mc_rd_addr_i,
    input  logic [31:0] mc_rd_data_i,
    output logic        mc_ready_o,
    output logic        pipe_stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_rd_data_o
);

    if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_fair_limit
        $error("FAIR_LIMIT must be in 1..15");
    end

    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [4:0]  r_addr_q [2];
    logic [31:0] r_data_q [2];

    logic w_stall;
    logic w_pipe_wr;
    logic w_push;
    logic w_pop;

`ifdef RF_ARB_FAIRNESS_EN
    logic [3:0] r_starve;
    logic       r_stall;

    assign w_stall = r_stall && !rst;

    // The flag is set on the cycle the counter reaches the limit, so the
    // stall lands on the very next cycle and the forced pop clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
            r_stall  <= 1'b0;
        end else if (w_pop) begin
            r_starve <= 4'd0;
            r_stall  <= 1'b0;
        end else if (r_count != 2'd0) begin
            r_starve <= r_starve + 4'd1;
            if (r_starve + 4'd1 == 4'(FAIR_LIMIT))
                r_stall <= 1'b1;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    assign pipe_stall_o = w_stall;
    assign mc_ready_o   = !rst && (r_count != 2'd2);
    assign w_pipe_wr    = !rst && pipe_we_i && (pipe_rd_addr_i != 5'd0) && !w_stall;
    assign w_pop        = !rst && (r_count != 2'd0) && !w_pipe_wr;
    // Results targeting x0 complete the handshake but are never stored.
    assign w_push       = mc_valid_i && mc_ready_o && (mc_rd_addr_i != 5'd0);

    always_comb begin
        rf_we_o      = 1'b0;
        rf_rd_addr_o = 5'd0;
        rf_rd_data_o = 32'd0;
        if (w_pop) begin
            rf_we_o      = 1'b1;
            rf_rd_addr_o = r_addr_q[r_rd_ptr];
            rf_rd_data_o = r_data_q[r_rd_ptr];
        end else if (w_pipe_wr) begin
            rf_we_o      = 1'b1;
            rf_rd_addr_o = pipe_rd_addr_i;
            rf_rd_data_o = pipe_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr] <= mc_rd_addr_i;
            r_data_q[r_wr_ptr] <= mc_rd_data_i;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed vector bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_addr_i;
    logic [31:0] pipe_rd_data_i;
    logic        mc_valid_i;
    logic [4:0]  mc_rd_addr_i;
    logic [31:0] mc_rd_data_i;
    logic        mc_ready_o;
    logic        pipe_stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_data_o;

    int errors = 0;
    int checks = 0;

    regfile_wr_arbiter #(.FAIR_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_we_i      (pipe_we_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_rd_data_i (pipe_rd_data_i),
        .mc_valid_i     (mc_valid_i),
        .mc_rd_addr_i   (mc_rd_addr_i),
        .mc_rd_data_i   (mc_rd_data_i),
        .mc_ready_o     (mc_ready_o),
        .pipe_stall_o   (pipe_stall_o),
        .rf_we_o        (rf_we_o),
        .rf_rd_addr_o   (rf_rd_addr_o),
        .rf_rd_data_o   (rf_rd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_we_i      = pwe;
        pipe_rd_addr_i = pa;
        pipe_rd_data_i = pd;
        mc_valid_i     = mv;
        mc_rd_addr_i   = ma;
        mc_rd_data_i   = md;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic rdy, input logic stall);
        @(negedge clk);
        chk({tag, "_we"},    32'(rf_we_o),      32'(we));
        chk({tag, "_addr"},  32'(rf_rd_addr_o), 32'(a));
        chk({tag, "_data"},  rf_rd_data_o,      d);
        chk({tag, "_ready"}, 32'(mc_ready_o),   32'(rdy));
        chk({tag, "_stall"}, 32'(pipe_stall_o), 32'(stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pwe pa pd | mv ma md | exp we addr data ready
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h11,  1'b0, 5'd0,  32'h0,        1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd7,  32'h11,       1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1};
        vecs[4]  = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA0,       1'b1};
        vecs[5]  = '{1'b1, 5'd11, 32'hA1,       1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hA1,       1'b1};
        vecs[6]  = '{1'b1, 5'd12, 32'hA2,       1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'hA2,       1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h103, 1'b1, 5'd1,  32'h101,      1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h103, 1'b1, 5'd2,  32'h102,      1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd3,  32'h103,      1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h99,  1'b0, 5'd0,  32'h0,        1'b1};
        vecs[11] = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0, 32'h77,  1'b1, 5'd9,  32'h99,       1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1};
        vecs[13] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1};

        // Reset held two cycles while both sources are active
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44);
        @(posedge clk);
        #1;
        expect_out("rst0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        expect_out("rst1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("rel0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        expect_out("rel1", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
            expect_out($sformatf("v%0d", i), vecs[i].ewe, vecs[i].ea, vecs[i].ed, vecs[i].erdy, 1'b0);
        end

        // Mid-operation reset discards a full FIFO
        drive(1'b1, 5'd15, 32'hB0, 1'b1, 5'd13, 32'h13);
        expect_out("fill0", 1'b1, 5'd15, 32'hB0, 1'b1, 1'b0);
        drive(1'b1, 5'd15, 32'hB1, 1'b1, 5'd14, 32'h14);
        expect_out("fill1", 1'b1, 5'd15, 32'hB1, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("mrst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_out("mrel0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        expect_out("mrel1", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        // Starvation: one pending entry while the pipeline writes every cycle
        drive(1'b1, 5'd21, 32'h200, 1'b1, 5'd20, 32'hF0);
        expect_out("st_acc", 1'b1, 5'd21, 32'h200, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 5'd21, 32'h300 + 32'(k), 1'b0, 5'd0, 32'h0);
`ifdef RF_ARB_FAIRNESS_EN
            if (k == 4)
                expect_out($sformatf("st%0d", k), 1'b1, 5'd20, 32'hF0, 1'b1, 1'b1);
            else
                expect_out($sformatf("st%0d", k), 1'b1, 5'd21, 32'h300 + 32'(k), 1'b1, 1'b0);
`else
            expect_out($sformatf("st%0d", k), 1'b1, 5'd21, 32'h300 + 32'(k), 1'b1, 1'b0);
`endif
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef RF_ARB_FAIRNESS_EN
        expect_out("st_idle", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
`else
        expect_out("st_idle", 1'b1, 5'd20, 32'hF0, 1'b1, 1'b0);
`endif
        expect_out("st_empty", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001: Parameter FAIR_LIMIT, default 4, consecutive starved cycles before a forced multi-cycle-unit grant (range 1..15).
REQ-002: clk  input  1  clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: pipe_we_i  input  1  pipeline writeback write enable.
REQ-005: pipe_rd_addr_i  input  5  pipeline destination register.
REQ-006: pipe_rd_data_i  input  32  pipeline writeback data.
REQ-007: mc_valid_i  input  1  multi-cycle unit (mul/div) result valid.
REQ-008: mc_rd_addr_i  input  5  multi-cycle result destination register.
REQ-009: mc_rd_data_i  input  32  multi-cycle result data.
REQ-010: mc_ready_o  output  1  arbiter can accept a multi-cycle result.
REQ-011: pipe_stall_o  output  1  pipeline must hold its writeback inputs this cycle.
REQ-012: rf_we_o  output  1  register-file write enable.
REQ-013: rf_rd_addr_o  output  5  register-file write address.
REQ-014: rf_rd_data_o  output  32  register-file write data.

Function
REQ-015: Multi-cycle results SHALL be held in a 2-entry in-order FIFO (pending buffer) with registered count 0..2.
REQ-016: Handshake: result accepted at the rising edge when mc_valid_i && mc_ready_o; mc_ready_o = (count < 2), from registered state only, no same-cycle full pass-through.
REQ-017: Accepted results with mc_rd_addr_i == 0 SHALL be dropped, not enqueued.
REQ-018: Port is free for the FIFO when pipe_we_i == 0 or pipe_rd_addr_i == 0, or pipe_stall_o == 1.
REQ-019: If FIFO non-empty and port free: rf_* SHALL present the FIFO head combinationally and the head pops at the clock edge.
REQ-020: Otherwise rf_* SHALL present the pipeline inputs combinationally (zero latency); rf_we_o = pipe_we_i && pipe_rd_addr_i != 0 && !pipe_stall_o.
REQ-021: rf_we_o SHALL never assert for address 0; when rf_we_o = 0, rf_rd_addr_o and rf_rd_data_o SHALL be 0.
REQ-022: Earliest write of an accepted result is the cycle after acceptance.
REQ-023: Simultaneous push and pop in one cycle SHALL be allowed; count unchanged, order preserved.
REQ-024: FIFO writes to the same rd SHALL retire in acceptance order; same-rd hazards against the pipeline are resolved by the hazard unit.
REQ-025: Pointers SHALL wrap modulo 2.

Reset
REQ-026: While rst = 1: count, pointers, starve counter, stall flag SHALL clear; rf_we_o = 0, mc_ready_o = 0, pipe_stall_o = 0.
REQ-027: Reset mid-operation SHALL discard all pending entries; no write issues in the reset cycle; mc_ready_o = 1 the first cycle after rst deasserts.

Configuration
REQ-028: With RF_ARB_FAIRNESS_EN defined: a 4-bit starve counter increments each cycle the FIFO is non-empty and not popped, clears on any pop.
REQ-029: With RF_ARB_FAIRNESS_EN defined: when the counter reaches FAIR_LIMIT, a registered stall flag sets, driving pipe_stall_o = 1 for exactly the next cycle; the FIFO head is written then, and counter and flag clear.
REQ-030: Without RF_ARB_FAIRNESS_EN: no starve counter or stall flag; pipe_stall_o tied 0; the pipeline always wins a busy port.

Verification
REQ-031: rst high 2 cycles with mc_valid_i=1 -> rf_we_o=0, mc_ready_o=0 in both; mc_ready_o=1 next cycle; nothing enqueued.
REQ-032: FIFO empty, pipe_we_i=1, rd=5, data=0xDEADBEEF -> same cycle rf_we_o=1, addr 5, data 0xDEADBEEF.
REQ-033: Pipe idle, mc accept rd=7 data=0x11 at cycle N -> cycle N+1 rf_we_o=1, addr 7, data 0x11; count back to 0.
REQ-034: Pipe writing every cycle, mc offers rd=1/2/3 back-to-back -> 2 accepted, mc_ready_o=0; on pipe idle writes rd 1 then 2; rd 3 then accepted.
REQ-035: FIFO holds rd=9, pipe_we_i=1 with rd=0 -> rd 9 written; mc accept rd=0 -> never written.
REQ-036: Macro defined, FAIR_LIMIT=4, FIFO non-empty, pipe busy cycles 0-3 -> cycle 4 pipe_stall_o=1, FIFO head written; cycle 5 pipe_stall_o=0. Macro undefined: pipe_stall_o stays 0.
